// File: rtl/reg_dump_reader_if.sv
// Bundle of the dump reader's control, register-file read and output stream signals.
// The checksum signal exists only when REG_DUMP_CHECKSUM_EN is defined.
interface reg_dump_reader_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] rf_raddr;
  logic [DATA_WIDTH-1:0] rf_rdata;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [DATA_WIDTH-1:0] out_data;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum;

  modport master (
    input  start, rf_rdata, out_ready,
    output busy, done, rf_raddr, out_valid, out_addr, out_data, checksum
  );
  modport slave (
    output start, rf_rdata, out_ready,
    input  busy, done, rf_raddr, out_valid, out_addr, out_data, checksum
  );
`else
  modport master (
    input  start, rf_rdata, out_ready,
    output busy, done, rf_raddr, out_valid, out_addr, out_data
  );
  modport slave (
    output start, rf_rdata, out_ready,
    input  busy, done, rf_raddr, out_valid, out_addr, out_data
  );
`endif
endinterface

// File: rtl/reg_dump_reader.sv
// Walks every register file entry once per start and streams (index, value) over a valid/ready port.
// Optional running XOR checksum of the streamed values when REG_DUMP_CHECKSUM_EN is defined.
module reg_dump_reader #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  reg_dump_reader_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, SEND, FIN} state_t;

  state_t                state;
  state_t                next_state;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  out_valid;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  handshake;
  logic                  last_entry;

  assign handshake  = out_valid && bus.out_ready;
  assign last_entry = &idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // One READ cycle latches the entry, SEND waits for the consumer; the last entry exits to FIN.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (bus.start) next_state = READ;
      READ: next_state = SEND;
      SEND: if (handshake) next_state = last_entry ? FIN : READ;
      FIN:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) idx <= '0;
        READ: begin
          out_data  <= bus.rf_rdata;
          out_addr  <= idx;
          out_valid <= 1'b1;
        end
        SEND: if (handshake) begin
          out_valid <= 1'b0;
          // idx parks on the last entry so it never wraps inside a dump
          if (!last_entry) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum;

  always_ff @(posedge clk) begin
    if (rst) begin
      checksum <= '0;
    end else if (state == IDLE && bus.start) begin
      checksum <= '0;
    end else if (state == SEND && handshake) begin
      checksum <= checksum ^ out_data;
    end
  end

  assign bus.checksum = checksum;
`endif

  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == FIN);
  assign bus.rf_raddr  = idx;
  assign bus.out_valid = out_valid;
  assign bus.out_addr  = out_addr;
  assign bus.out_data  = out_data;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Randomized-ready bench for reg_dump_reader against an in-order dump scoreboard.
// Checksum checks are compiled in with REG_DUMP_CHECKSUM_EN.
module tb_reg_dump_reader;
  localparam int AW = 2;
  localparam int DW = 8;
  localparam int N  = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic [DW-1:0] rf_mem [N];

  reg_dump_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  reg_dump_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  assign bus.rf_rdata = rf_mem[bus.rf_raddr];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: entry k of a dump must be (k, rf_mem[k]); done follows the 4th entry.
  int            hs_count = 0;
  int            done_count = 0;
  int            last_hs_cyc = 0;
  int            start_cyc = 0;
  bit            full_speed = 0;
  bit            prev_hold = 0;
  logic [AW-1:0] held_addr;
  logic [DW-1:0] held_data;
  logic [DW-1:0] cs_model = '0;

  always @(negedge clk) begin
    if (rst) begin
      hs_count  = 0;
      prev_hold = 0;
      cs_model  = '0;
    end else begin
      if (prev_hold) begin
        checkOutput("hold_valid", 32'(bus.out_valid), 1);
        checkOutput("hold_addr", 32'(bus.out_addr), 32'(held_addr));
        checkOutput("hold_data", 32'(bus.out_data), 32'(held_data));
      end
      if (bus.busy === 1'b0) begin
        checkOutput("idle_valid", 32'(bus.out_valid), 0);
`ifdef REG_DUMP_CHECKSUM_EN
        checkOutput("idle_checksum", 32'(bus.checksum), 32'(cs_model));
`endif
        if (bus.start) begin
          hs_count  = 0;
          cs_model  = '0;
          start_cyc = cyc;
        end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (full_speed)
          checkOutput("hs_spacing", cyc - ((hs_count == 0) ? start_cyc : last_hs_cyc), 2);
        checkOutput("hs_addr", 32'(bus.out_addr), hs_count);
        checkOutput("hs_data", 32'(bus.out_data), 32'(rf_mem[hs_count % N]));
        cs_model    = cs_model ^ rf_mem[hs_count % N];
        hs_count++;
        last_hs_cyc = cyc;
      end
      prev_hold = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
      held_addr = bus.out_addr;
      held_data = bus.out_data;
      if (bus.done === 1'b1) begin
        done_count++;
        checkOutput("done_busy", 32'(bus.busy), 1);
        checkOutput("done_entries", hs_count, N);
        checkOutput("done_timing", cyc - last_hs_cyc, 1);
`ifdef REG_DUMP_CHECKSUM_EN
        checkOutput("done_checksum", 32'(bus.checksum), 32'(cs_model));
        checkOutput("done_checksum_abs", 32'(bus.checksum), 32'h44);
`endif
      end
    end
  end

  // mode 0: ready held high, 1: random ready, 2: 5-cycle stall at entry 2, 3: start re-pulsed at entry 1 and in FIN
  task automatic applyStimulus(input int mode);
    int d0 = done_count;
    int n = 0;
    int stall = 0;
    full_speed    = (mode == 0);
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    stepCycle();
    bus.start = 1'b0;
    while (done_count == d0 && n < 200) begin
      case (mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = 1'($urandom_range(0, 1));
        2: begin
          if (bus.out_valid && bus.out_addr == 2 && stall < 5) begin
            bus.out_ready = 1'b0;
            stall++;
          end else begin
            bus.out_ready = 1'b1;
          end
        end
        default: begin
          bus.out_ready = 1'b1;
          bus.start = (bus.out_valid && bus.out_addr == 1) || bus.done;
        end
      endcase
      stepCycle();
      n++;
    end
    bus.start  = 1'b0;
    full_speed = 0;
    checkOutput("dump_timeout", 32'(n < 200), 1);
    checkOutput("busy_after_done", 32'(bus.busy), 0);
    if (mode == 2) checkOutput("stall_cycles", stall, 5);
    repeat (3) stepCycle();
    checkOutput("busy_stays_low", 32'(bus.busy), 0);
    checkOutput("done_once", done_count - d0, 1);
  endtask

  initial begin
    int n;
    int d0;
    rf_mem = '{8'h11, 8'h22, 8'h33, 8'h44};
    rst = 1'b1;
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) stepCycle();
    checkOutput("rst_busy", 32'(bus.busy), 0);
    checkOutput("rst_done", 32'(bus.done), 0);
    checkOutput("rst_valid", 32'(bus.out_valid), 0);
    checkOutput("rst_addr", 32'(bus.out_addr), 0);
    checkOutput("rst_data", 32'(bus.out_data), 0);
    checkOutput("rst_raddr", 32'(bus.rf_raddr), 0);

    bus.start = 1'b1;
    stepCycle();
    checkOutput("rst_start_busy", 32'(bus.busy), 0);
    bus.start = 1'b0;
    rst = 1'b0;
    stepCycle();
    checkOutput("rst_start_idle", 32'(bus.busy), 0);

    applyStimulus(0);
    applyStimulus(0);
    applyStimulus(2);
    applyStimulus(3);

    // Reset in SEND at entry 2 abandons the dump
    d0 = done_count;
    n = 0;
    bus.out_ready = 1'b1;
    bus.start = 1'b1;
    stepCycle();
    bus.start = 1'b0;
    while (!(bus.out_valid && bus.out_addr == 2) && n < 50) begin
      stepCycle();
      n++;
    end
    checkOutput("rst_reach_entry2", 32'(n < 50), 1);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkOutput("midrst_valid", 32'(bus.out_valid), 0);
    checkOutput("midrst_busy", 32'(bus.busy), 0);
    checkOutput("midrst_addr", 32'(bus.out_addr), 0);
    checkOutput("midrst_data", 32'(bus.out_data), 0);
    repeat (3) stepCycle();
    checkOutput("midrst_no_done", done_count - d0, 0);
    applyStimulus(0);

    repeat (4) applyStimulus(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_dump_reader.md
REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, SHALL set the address width of the scanned register file (2**ADDR_WIDTH entries).
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the register data width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 start  input  1  SHALL request one full dump when sampled high in IDLE.
REQ-006 busy  output  1  SHALL be high in every state except IDLE.
REQ-007 done  output  1  SHALL be a one-cycle pulse after the last entry is accepted.
REQ-008 rf_raddr  output  ADDR_WIDTH  SHALL be the read address driven to the register file's asynchronous read port.
REQ-009 rf_rdata  input  DATA_WIDTH  SHALL be the combinational read data returned for rf_raddr in the same cycle.
REQ-010 out_valid  output  1  SHALL flag that out_addr/out_data hold a valid entry.
REQ-011 out_ready  input  1  SHALL be the consumer's accept signal.
REQ-012 out_addr  output  ADDR_WIDTH  SHALL be the index of the presented entry.
REQ-013 out_data  output  DATA_WIDTH  SHALL be the registered value of the presented entry.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, READ, SEND and FIN.
REQ-015 IDLE with start=1 SHALL go to READ and clear the index counter idx to 0; start in any other state SHALL be ignored.
REQ-016 rf_raddr SHALL equal idx in all states.
REQ-017 READ SHALL latch out_data<=rf_rdata and out_addr<=idx, set out_valid, and go to SEND in one cycle.
REQ-018 SEND SHALL hold out_valid, out_addr and out_data stable until out_valid&&out_ready.
REQ-019 On a SEND handshake with idx<2**ADDR_WIDTH-1, the block SHALL increment idx, clear out_valid and go to READ.
REQ-020 Throughput SHALL be one entry per 2 cycles with out_ready held high.
REQ-021 On a SEND handshake with idx=2**ADDR_WIDTH-1, the block SHALL clear out_valid and go to FIN; idx SHALL never wrap to 0 within a dump.
REQ-022 FIN SHALL assert done for exactly one cycle, then go to IDLE.
REQ-023 start=1 sampled in the FIN cycle SHALL be ignored; a new dump SHALL need start in IDLE.
REQ-024 out_valid SHALL never depend combinationally on out_ready.
REQ-025 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-026 rst=1 SHALL force state=IDLE, idx=0, out_valid=0, out_addr=0, out_data=0, done=0, busy=0 at the next posedge, in any state.
REQ-027 rst SHALL take priority over start and over a same-cycle handshake.
REQ-028 A dump interrupted by rst SHALL be abandoned with no done pulse.

Configuration
REQ-029 With REG_DUMP_CHECKSUM_EN defined, the block SHALL add output checksum (DATA_WIDTH):
  - cleared to 0 on start acceptance and on rst;
  - XORed with out_data on every handshake;
  - stable from the done cycle until the next accepted start.
REQ-030 Without REG_DUMP_CHECKSUM_EN, the checksum port and its logic SHALL be absent, with all other behaviour identical.

Verification
Bench parameters: ADDR_WIDTH=2, DATA_WIDTH=8; register file contents {0x11,0x22,0x33,0x44}.
REQ-031 start pulse, out_ready=1 -> handshakes (0,0x11),(1,0x22),(2,0x33),(3,0x44) on every 2nd cycle; done one cycle after the last handshake; busy low after.
REQ-032 out_ready=0 for 5 cycles at entry 2 -> out_valid=1 with (2,0x33) held stable; resume -> no entry lost or duplicated.
REQ-033 start pulsed again while busy at entry 1 -> ignored: exactly 4 entries and 1 done.
REQ-034 rst at entry 2 in SEND -> next cycle out_valid=0, busy=0, no done; fresh start -> dump restarts at entry 0.
REQ-035 With REG_DUMP_CHECKSUM_EN, full dump -> checksum=0x44 at done; second dump -> still 0x44 (cleared at start).
REQ-036 rst and start high together in IDLE -> remains IDLE, busy=0.
